// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of a shared combinational 16-bit ALU (ADD/NAND/EQ).
// Sequences one operation at a time (IDLE -> EXEC -> RESP) and owns the C/Z flags.
module alu_share_arbiter #(
  parameter int         ARB_MODE = 0,
  parameter logic [1:0] FLAG_RST = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [1:0]  req0_cz,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [1:0]  req1_cz,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  alu_cz_mod,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  input  logic [15:0] alu_out,
  input  logic        alu_c,
  input  logic        alu_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        c_flag,
  output logic        z_flag
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ILL = 2'b11;

  function automatic logic [15:0] rsp_result(input logic [1:0] op, input logic [15:0] res);
    return (op == OP_ILL) ? 16'h0000 : res;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d, cz_q, cz_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic        id_q, id_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        c_flag_q, c_flag_d, z_flag_q, z_flag_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_err_q, rsp_err_d;
  logic        gnt_valid, gnt_id;

  // Z is derived from alu_out directly; the ALU's own zero output is not needed.
  logic unused_alu_z;
  assign unused_alu_z = alu_z;

  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) gnt_id = (ARB_MODE != 0) ? 1'b0 : rr_ptr_q;
    else                          gnt_id = req1_valid;
    gnt_valid  = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
    req0_ready = gnt_valid && !gnt_id;
    req1_ready = gnt_valid && gnt_id;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cz_d       = cz_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    rr_ptr_d   = rr_ptr_q;
    c_flag_d   = c_flag_q;
    z_flag_d   = z_flag_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d  = EXEC;
          id_d     = gnt_id;
          op_d     = gnt_id ? req1_op : req0_op;
          cz_d     = gnt_id ? req1_cz : req0_cz;
          a_d      = gnt_id ? req1_a  : req0_a;
          b_d      = gnt_id ? req1_b  : req0_b;
          rr_ptr_d = ~gnt_id;
        end
      end
      EXEC: begin
        state_d    = RESP;
        rsp_data_d = rsp_result(op_q, alu_out);
        rsp_id_d   = id_q;
        rsp_err_d  = (op_q == OP_ILL);
        if (cz_q[1] && (op_q == OP_ADD)) c_flag_d = alu_c;
        if (cz_q[0] && (op_q != OP_ILL)) z_flag_d = (alu_out == 16'h0000);
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      c_flag_q   <= FLAG_RST[1];
      z_flag_q   <= FLAG_RST[0];
      rsp_data_q <= 16'h0000;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      c_flag_q   <= c_flag_d;
      z_flag_q   <= z_flag_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Latched operands: only read in EXEC, so no reset needed
  always_ff @(posedge clk) begin
    op_q <= op_d;
    cz_q <= cz_d;
    a_q  <= a_d;
    b_q  <= b_d;
    id_q <= id_d;
  end

  always_comb begin
    alu_op     = 2'b00;
    alu_cz_mod = 2'b00;
    alu_in1    = 16'h0000;
    alu_in2    = 16'h0000;
    if (state_q == EXEC) begin
      alu_op     = op_q;
      alu_cz_mod = cz_q;
      alu_in1    = a_q;
      alu_in2    = b_q;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign c_flag    = c_flag_q;
  assign z_flag    = z_flag_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the alu_* ports.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req0_cz, req1_op, req1_cz;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  alu_op, alu_cz_mod;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic        alu_c, alu_z;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, c_flag, z_flag;
  logic [15:0] rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.ARB_MODE(0), .FLAG_RST(2'b00)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_cz(req0_cz),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_cz(req1_cz),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_cz_mod(alu_cz_mod), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .c_flag(c_flag), .z_flag(z_flag)
  );

  // ALU model; the illegal encoding returns garbage so the arbiter must mask it
  always_comb begin
    alu_c   = 1'b0;
    alu_out = 16'h0000;
    case (alu_op)
      2'b00:   {alu_c, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
      2'b01:   alu_out = ~(alu_in1 & alu_in2);
      2'b10:   alu_out = (alu_in1 == alu_in2) ? 16'h0001 : 16'h0000;
      default: alu_out = 16'hDEAD;
    endcase
    alu_z = (alu_out == 16'h0000);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [1:0] op, input logic [1:0] cz,
                         input logic [15:0] a, input logic [15:0] b);
    if (p == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_cz = cz; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_cz = cz; req1_a = a; req1_b = b;
    end
  endtask

  task automatic clr_req(input int p);
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rsp_ready = 1'b0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_cz = 2'b00; req1_a = 16'h0; req1_b = 16'h0;
    set_req(0, 2'b00, 2'b11, 16'h0001, 16'h0001);
    rst = 1'b1;
    tick(); tick();
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %b want 0", req0_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h want 0000", rsp_data); end
    checks++; if ({rsp_id, rsp_err} !== 2'b00) begin errors++; $display("FAIL reset_id_err got %b want 00", {rsp_id, rsp_err}); end
    checks++; if ({c_flag, z_flag} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {c_flag, z_flag}); end
    checks++; if ({alu_op, alu_in1} !== 18'h0) begin errors++; $display("FAIL reset_alu got %h want 0", {alu_op, alu_in1}); end
    clr_req(0);
    rst = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_rsp_valid got %b want 0", rsp_valid); end
  endtask

  task automatic test_add_flags();
    set_req(0, 2'b00, 2'b11, 16'hFFFF, 16'h0001);
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL add_ready got %b want 10", {req0_ready, req1_ready}); end
    tick();
    clr_req(0);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_t1_valid got %b want 0", rsp_valid); end
    checks++; if ({alu_op, alu_cz_mod} !== 4'b0011) begin errors++; $display("FAIL add_alu_ctl got %b want 0011", {alu_op, alu_cz_mod}); end
    checks++; if ({alu_in1, alu_in2} !== 32'hFFFF_0001) begin errors++; $display("FAIL add_alu_in got %h want ffff0001", {alu_in1, alu_in2}); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL add_exec_ready got %b want 00", {req0_ready, req1_ready}); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_t2_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL add_data got %h want 0000", rsp_data); end
    checks++; if ({rsp_id, rsp_err} !== 2'b00) begin errors++; $display("FAIL add_id_err got %b want 00", {rsp_id, rsp_err}); end
    checks++; if ({c_flag, z_flag} !== 2'b11) begin errors++; $display("FAIL add_flags got %b want 11", {c_flag, z_flag}); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_release got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int i0, i1;
    logic exp_id;
    logic [15:0] exp_data;
    rst = 1'b1; tick(); rst = 1'b0;
    rsp_ready = 1'b1;
    i0 = 0; i1 = 0;
    set_req(0, 2'b00, 2'b00, 16'h0010, 16'h0001);
    set_req(1, 2'b00, 2'b00, 16'h2000, 16'h0300);
    for (int k = 0; k < 8; k++) begin
      exp_id = k[0];
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
        errors++; $display("FAIL rr_grant_%0d got %b want %b", k, {req0_ready, req1_ready}, {~exp_id, exp_id});
      end
      tick();
      if (exp_id == 1'b0) begin
        exp_data = 16'h0010 + 16'(i0) + 16'h0001;
        i0++;
        if (i0 < 4) set_req(0, 2'b00, 2'b00, 16'h0010 + 16'(i0), 16'h0001);
        else        clr_req(0);
      end else begin
        exp_data = 16'h2000 + 16'(i1) + 16'h0300;
        i1++;
        if (i1 < 4) set_req(1, 2'b00, 2'b00, 16'h2000 + 16'(i1), 16'h0300);
        else        clr_req(1);
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, exp_id, exp_data}) begin
        errors++; $display("FAIL rr_rsp_%0d got v=%b id=%b d=%h want v=1 id=%b d=%h", k, rsp_valid, rsp_id, rsp_data, exp_id, exp_data);
      end
      tick();
    end
    rsp_ready = 1'b0;
    checks++; if ({c_flag, z_flag} !== 2'b00) begin errors++; $display("FAIL rr_flags got %b want 00", {c_flag, z_flag}); end
  endtask

  task automatic test_nand_keep_c();
    set_req(0, 2'b00, 2'b11, 16'hFFFF, 16'h0002);
    tick(); clr_req(0); tick();
    checks++; if ({rsp_data, c_flag, z_flag} !== {16'h0001, 2'b10}) begin errors++; $display("FAIL setc got d=%h cz=%b want d=0001 cz=10", rsp_data, {c_flag, z_flag}); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    set_req(1, 2'b01, 2'b10, 16'hFFFF, 16'hFFFF);
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL nand_ready got %b want 01", {req0_ready, req1_ready}); end
    tick(); clr_req(1); tick();
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {2'b11, 16'h0000}) begin errors++; $display("FAIL nand_rsp got v=%b id=%b d=%h want v=1 id=1 d=0000", rsp_valid, rsp_id, rsp_data); end
    checks++; if ({c_flag, z_flag} !== 2'b10) begin errors++; $display("FAIL nand_flags got %b want 10", {c_flag, z_flag}); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    set_req(0, 2'b00, 2'b00, 16'h1234, 16'h1111);
    tick();
    set_req(0, 2'b10, 2'b00, 16'h0001, 16'h0002);
    set_req(1, 2'b01, 2'b00, 16'h0003, 16'h0004);
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_exec_ready got %b want 00", {req0_ready, req1_ready}); end
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {2'b10, 16'h2345}) begin
        errors++; $display("FAIL bp_hold_%0d got v=%b id=%b d=%h want v=1 id=0 d=2345", k, rsp_valid, rsp_id, rsp_data);
      end
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        errors++; $display("FAIL bp_ready_%0d got %b want 00", k, {req0_ready, req1_ready});
      end
      tick();
    end
    clr_req(0); clr_req(1);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", rsp_valid); end
  endtask

  task automatic test_illegal();
    set_req(0, 2'b00, 2'b01, 16'h0000, 16'h0000);
    tick(); clr_req(0); tick();
    checks++; if ({c_flag, z_flag} !== 2'b11) begin errors++; $display("FAIL setz got %b want 11", {c_flag, z_flag}); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    set_req(1, 2'b11, 2'b11, 16'h0000, 16'h0000);
    tick(); clr_req(1);
    checks++; if (alu_op !== 2'b11) begin errors++; $display("FAIL ill_alu_op got %b want 11", alu_op); end
    tick();
    checks++; if ({rsp_valid, rsp_err, rsp_id, rsp_data} !== {3'b111, 16'h0000}) begin errors++; $display("FAIL ill_rsp got v=%b e=%b id=%b d=%h want v=1 e=1 id=1 d=0000", rsp_valid, rsp_err, rsp_id, rsp_data); end
    checks++; if ({c_flag, z_flag} !== 2'b11) begin errors++; $display("FAIL ill_flags got %b want 11", {c_flag, z_flag}); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    set_req(0, 2'b10, 2'b00, 16'h0005, 16'h0005);
    tick(); clr_req(0); tick();
    checks++; if ({rsp_err, rsp_data} !== {1'b0, 16'h0001}) begin errors++; $display("FAIL eq_rsp got e=%b d=%h want e=0 d=0001", rsp_err, rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_exec();
    set_req(0, 2'b00, 2'b11, 16'hFFFF, 16'h0001);
    tick(); clr_req(0);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstx_valid got %b want 0", rsp_valid); end
    checks++; if ({c_flag, z_flag} !== 2'b00) begin errors++; $display("FAIL rstx_flags got %b want 00", {c_flag, z_flag}); end
    checks++; if ({alu_op, alu_in1, rsp_data} !== 34'h0) begin errors++; $display("FAIL rstx_idle got op=%b in1=%h d=%h want 0", alu_op, alu_in1, rsp_data); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstx_valid2 got %b want 0", rsp_valid); end
    set_req(0, 2'b00, 2'b00, 16'h0001, 16'h0001);
    set_req(1, 2'b00, 2'b00, 16'h0002, 16'h0002);
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rstx_rrptr got %b want 10", {req0_ready, req1_ready}); end
    tick(); clr_req(0); clr_req(1); tick();
    checks++; if ({rsp_id, rsp_data} !== {1'b0, 16'h0002}) begin errors++; $display("FAIL rstx_rsp got id=%b d=%h want id=0 d=0002", rsp_id, rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    set_req(0, 2'b00, 2'b00, 16'h0003, 16'h0004);
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_win got %b want 10", {req0_ready, req1_ready}); end
    tick(); clr_req(0); tick();
    checks++; if (rsp_data !== 16'h0007) begin errors++; $display("FAIL single_rsp got %h want 0007", rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = 2'b00; req0_cz = 2'b00; req0_a = 16'h0; req0_b = 16'h0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_cz = 2'b00; req1_a = 16'h0; req1_b = 16'h0;
    tick();
    test_reset();
    test_add_flags();
    test_round_robin();
    test_nand_keep_c();
    test_backpressure();
    test_illegal();
    test_reset_in_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
